// File: rtl/vector_denormalizer.sv
// Rebuilds integer vector components from fixed-point normalized quotients and a magnitude.
// A single shared multiplier handles one component per cycle, in the order A, B, C, D.
module vector_denormalizer #(
  parameter int DATAWIDTH = 8,
  parameter int FRAC_BITS = 8,
  parameter int QW        = 2*DATAWIDTH+2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 i_valid,
  output logic                 i_ready,
  input  logic [QW-1:0]        Q_A,
  input  logic [QW-1:0]        Q_B,
  input  logic [QW-1:0]        Q_C,
  input  logic [QW-1:0]        Q_D,
  input  logic [QW-1:0]        mag,
  output logic                 o_valid,
  output logic [DATAWIDTH-1:0] out_A,
  output logic [DATAWIDTH-1:0] out_B,
  output logic [DATAWIDTH-1:0] out_C,
  output logic [DATAWIDTH-1:0] out_D,
  output logic                 o_sat
);

  // One spare bit above the full product so the rounding add can never wrap.
  localparam int PW = 2*QW+1;
  localparam logic [PW-1:0] HALF = PW'(1) << (FRAC_BITS-1);
  localparam logic [PW-1:0] MAXV = (PW'(1) << DATAWIDTH) - PW'(1);

  typedef enum logic {IDLE = 1'b0, CALC = 1'b1} state_t;

  state_t               state_reg, state_next;
  logic [1:0]           index_reg;
  logic [QW-1:0]        q_reg [4];
  logic [QW-1:0]        mag_reg;
  logic [DATAWIDTH-1:0] out_reg [4];
  logic                 sat_acc_reg;
  logic                 o_valid_reg;
  logic                 o_sat_reg;

  logic                 accept;
  logic [QW-1:0]        q_sel;
  logic [2*QW-1:0]      prod;
  logic [PW-1:0]        rounded;
  logic [PW-1:0]        quot;
  logic                 comp_sat;
  logic [DATAWIDTH-1:0] comp_val;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (i_valid) state_next = CALC;
      CALC:    if (index_reg == 2'd3) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Output decode
  always_comb begin
    i_ready = (state_reg == IDLE);
  end

  assign accept   = i_valid && i_ready;
  assign q_sel    = q_reg[index_reg];
  assign prod     = {{QW{1'b0}}, q_sel} * {{QW{1'b0}}, mag_reg};
  assign rounded  = {1'b0, prod} + HALF;
  assign quot     = rounded >> FRAC_BITS;
  assign comp_sat = (quot > MAXV);
  assign comp_val = comp_sat ? {DATAWIDTH{1'b1}} : quot[DATAWIDTH-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      index_reg   <= 2'd0;
      mag_reg     <= '0;
      sat_acc_reg <= 1'b0;
      o_valid_reg <= 1'b0;
      o_sat_reg   <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        q_reg[i]   <= '0;
        out_reg[i] <= '0;
      end
    end else begin
      o_valid_reg <= 1'b0;
      if (accept) begin
        q_reg[0]    <= Q_A;
        q_reg[1]    <= Q_B;
        q_reg[2]    <= Q_C;
        q_reg[3]    <= Q_D;
        mag_reg     <= mag;
        index_reg   <= 2'd0;
        sat_acc_reg <= 1'b0;
      end else if (state_reg == CALC) begin
        out_reg[index_reg] <= comp_val;
        sat_acc_reg        <= sat_acc_reg | comp_sat;
        index_reg          <= index_reg + 2'd1;
        // The final component closes the operation; o_sat then holds until the next one.
        if (index_reg == 2'd3) begin
          o_valid_reg <= 1'b1;
          o_sat_reg   <= sat_acc_reg | comp_sat;
        end
      end
    end
  end

  assign o_valid = o_valid_reg;
  assign o_sat   = o_sat_reg;
  assign out_A   = out_reg[0];
  assign out_B   = out_reg[1];
  assign out_C   = out_reg[2];
  assign out_D   = out_reg[3];

endmodule

// File: tb/tb_vector_denormalizer.sv
// Random and directed stimulus for vector_denormalizer; a monitor checks each result
// against expectations queued by the driver from an arithmetic reference model.
module tb_vector_denormalizer;
  localparam int DW = 8;
  localparam int FB = 8;
  localparam int QW = 2*DW+2;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          i_valid = 1'b0;
  logic          i_ready;
  logic [QW-1:0] q_a = '0, q_b = '0, q_c = '0, q_d = '0, mag = '0;
  logic          o_valid;
  logic [DW-1:0] out_a, out_b, out_c, out_d;
  logic          o_sat;

  vector_denormalizer #(.DATAWIDTH(DW), .FRAC_BITS(FB), .QW(QW)) dut (
    .clk(clk), .rst(rst), .i_valid(i_valid), .i_ready(i_ready),
    .Q_A(q_a), .Q_B(q_b), .Q_C(q_c), .Q_D(q_d), .mag(mag),
    .o_valid(o_valid), .out_A(out_a), .out_B(out_b), .out_C(out_c), .out_D(out_d),
    .o_sat(o_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] o [4];
    logic          sat;
    int            due;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  int   busy = 0;
  int   n_results = 0;
  logic prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void chk(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d at cycle %0d", name, act, req, cyc);
    end
  endfunction

  // Reference: round-half-up of q*m / 2^FB, clamped to the DW-bit range.
  function automatic void ref_comp(input logic [QW-1:0] q, input logic [QW-1:0] m,
                                   output logic [DW-1:0] o, output logic s);
    longint unsigned qq, mm, r;
    qq = q;
    mm = m;
    r  = (qq * mm + (64'd1 << (FB-1))) / (64'd1 << FB);
    s  = (r > (64'd1 << DW) - 1);
    o  = s ? {DW{1'b1}} : DW'(r);
  endfunction

  function automatic logic [QW-1:0] rnd_val();
    case ($urandom_range(0, 3))
      0:       return '0;
      1:       return QW'($urandom_range(0, (1 << QW) - 1));
      2:       return QW'($urandom_range(0, 1023));
      default: return QW'($urandom_range(0, 600));
    endcase
  endfunction

  task automatic step(input logic r, input logic v, input logic [QW-1:0] a, input logic [QW-1:0] b,
                      input logic [QW-1:0] c, input logic [QW-1:0] d, input logic [QW-1:0] m);
    exp_t e;
    logic acc;
    logic [QW-1:0] qs [4];
    rst = r; i_valid = v; q_a = a; q_b = b; q_c = c; q_d = d; mag = m;
    qs[0] = a; qs[1] = b; qs[2] = c; qs[3] = d;
    @(negedge clk);
    chk("i_ready", {63'd0, i_ready}, {63'd0, busy == 0});
    acc = !r && v && (busy == 0);
    if (acc) begin
      e.sat = 1'b0;
      for (int k = 0; k < 4; k++) begin
        logic s;
        ref_comp(qs[k], m, e.o[k], s);
        e.sat = e.sat | s;
      end
      e.due = cyc + 5;
      sb.push_back(e);
    end
    @(posedge clk);
    if (r) begin
      if (busy > 0) sb.delete(sb.size() - 1);
      busy = 0;
    end else if (acc) begin
      busy = 4;
    end else if (busy > 0) begin
      busy--;
    end
    #1;
    if (r) begin
      chk("rst_o_valid", {63'd0, o_valid}, 64'd0);
      chk("rst_i_ready", {63'd0, i_ready}, 64'd1);
      chk("rst_o_sat", {63'd0, o_sat}, 64'd0);
      chk("rst_outs", {32'd0, out_a, out_b, out_c, out_d}, 64'd0);
    end
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 1'b0, '0, '0, '0, '0, '0);
  endtask

  // Monitor: every o_valid pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (o_valid) begin
      chk("o_valid_width", {63'd0, prev_ov}, 64'd0);
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_o_valid actual=1 required=0 at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("latency", 64'(cyc), 64'(e.due));
        chk("out_A", {56'd0, out_a}, {56'd0, e.o[0]});
        chk("out_B", {56'd0, out_b}, {56'd0, e.o[1]});
        chk("out_C", {56'd0, out_c}, {56'd0, e.o[2]});
        chk("out_D", {56'd0, out_d}, {56'd0, e.o[3]});
        chk("o_sat", {63'd0, o_sat}, {63'd0, e.sat});
        n_results++;
        $display("result %0d cycle %0d: out=%0d,%0d,%0d,%0d sat=%0d", n_results, cyc,
                 out_a, out_b, out_c, out_d, o_sat);
      end
    end
    prev_ov <= o_valid;
  end

  initial begin
    // Reset, then idle
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    idle(2);
    // Round trip
    step(1'b0, 1'b1, 18'd153, 18'd204, 18'd0, 18'd0, 18'd5);
    idle(5);
    // Rounding boundary with unit magnitude
    step(1'b0, 1'b1, 18'd128, 18'd127, 18'd383, 18'd384, 18'd1);
    idle(5);
    // Saturation followed by a clean vector
    step(1'b0, 1'b1, 18'd256, 18'd0, 18'd0, 18'd0, 18'd300);
    idle(4);
    step(1'b0, 1'b1, 18'd300, 18'd10, 18'd256, 18'd1, 18'd200);
    idle(5);
    // Zero magnitude
    step(1'b0, 1'b1, 18'd9999, 18'd77, 18'd1, 18'd5000, 18'd0);
    idle(5);
    // Simultaneous reset and valid: nothing accepted
    step(1'b1, 1'b1, 18'd500, 18'd500, 18'd500, 18'd500, 18'd500);
    idle(6);
    // Reset at E2 aborts the operation; a fresh vector right after completes normally
    step(1'b0, 1'b1, 18'd400, 18'd400, 18'd400, 18'd400, 18'd400);
    step(1'b0, 1'b0, '0, '0, '0, '0, '0);
    step(1'b1, 1'b0, '0, '0, '0, '0, '0);
    step(1'b0, 1'b1, 18'd600, 18'd50, 18'd700, 18'd0, 18'd90);
    idle(5);
    // i_valid held high with data changing every cycle
    for (int k = 0; k < 60; k++)
      step(1'b0, 1'b1, rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val());
    // Random valid pattern
    for (int k = 0; k < 150; k++)
      step(1'b0, 1'($urandom_range(0, 1)), rnd_val(), rnd_val(), rnd_val(), rnd_val(), rnd_val());
    // Drain, bounded
    for (int k = 0; k < 10 && sb.size() > 0; k++) idle(1);
    idle(2);
    chk("drain_outstanding", 64'(sb.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vector_denormalizer.md
Name: vector_denormalizer

Overview:
- Inverse of the normalization datapath: takes a 4-component normalized vector (fixed-point quotients, FRAC_BITS fractional bits) and its magnitude, and reconstructs the original integer components.
- Output per component: round(Q_x * mag / 2^FRAC_BITS), saturated to DATAWIDTH bits.
- One shared multiplier is time-multiplexed across the four components by a small FSM, so the block has a busy/ready handshake.
- Sits downstream of the normalizer, or on the decode side of any path carrying normalized vectors plus a norm.

Parameters:
- DATAWIDTH, 8, width of reconstructed components (matches normalizer input width).
- FRAC_BITS, 8, fractional bits in Q inputs.
- QW, 2*DATAWIDTH+2, width of Q and magnitude inputs (matches normalizer quotient/root width).

Ports:
- clk  input  1  clock, all state on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_valid  input  1  input vector valid; accepted only when i_ready=1.
- i_ready  output  1  block idle and able to accept.
- Q_A, Q_B, Q_C, Q_D  input  QW each  normalized components, unsigned, FRAC_BITS fraction.
- mag  input  QW  unsigned integer magnitude.
- o_valid  output  1  one-cycle pulse; results valid.
- out_A, out_B, out_C, out_D  output  DATAWIDTH each  reconstructed components.
- o_sat  output  1  at least one component saturated in the current result; valid with o_valid, held afterward.

Behaviour:
- Reset: state IDLE, i_ready=1, o_valid=0, out_A..out_D=0, o_sat=0, index=0, all input latches=0.
- FSM states:
  - IDLE: i_ready=1. On i_valid=1 at a rising edge (E0), latch Q_A..Q_D and mag, clear the sat accumulator, set index=0, go to CALC.
  - CALC: i_ready=0. Each edge computes one component in order A, B, C, D (index 0..3, one per edge E1..E4).
  - At E4, with index=3: register o_valid=1, update o_sat, return to IDLE.
- Arithmetic per component:
  - p = Q_x * mag, full 2*QW-bit product, no truncation.
  - r = (p + 2^(FRAC_BITS-1)) >> FRAC_BITS, round half up.
  - out_x = r when r <= 2^DATAWIDTH-1; otherwise out_x = 2^DATAWIDTH-1 and that component's sat bit is set.
- Update timing:
  - Each out_x register updates at its own CALC edge.
  - All four out_x registers are final when o_valid=1.
  - Outputs hold until overwritten by the next operation.
- Latency and throughput:
  - o_valid is high in the cycle after E4, i.e. 4 edges after acceptance.
  - i_ready returns high in that same cycle, so the next accept can occur at E5.
  - Throughput is 1 vector per 5 cycles.
- o_valid is exactly one cycle wide; it deasserts at E5 regardless of i_valid.
- i_valid while i_ready=0: ignored, inputs not latched, no effect on the operation in flight. Upstream must hold or drop.
- Input stability: inputs are needed only at the accept edge; later changes have no effect.
- mag=0 or Q=0: the result is 0 with no saturation; this is not an error.
- Reset mid-CALC: the operation is aborted. At the next edge after rst deasserts, all outputs equal reset values, o_valid never pulses for the aborted vector, and i_ready=1.
- Simultaneous rst and i_valid: rst wins; nothing is accepted.
- All arithmetic is unsigned. No signed inputs are supported.

Test Plan:
- Reset then idle: rst high 2 cycles, no i_valid -> i_ready=1, o_valid=0, all outputs 0, o_sat=0.
- Round trip (DATAWIDTH=8, FRAC_BITS=8): Q_A=153, Q_B=204, Q_C=0, Q_D=0, mag=5, accepted at E0 -> o_valid pulse exactly 4 edges later; out_A=3, out_B=4, out_C=0, out_D=0, o_sat=0.
- Rounding boundary, mag=1:
  - Q_A=128 -> out_A=1 (half up).
  - Q_B=127 -> out_B=0.
  - Q_C=383 -> out_C=1.
  - Q_D=384 -> out_D=2.
- Saturation: Q_A=256, mag=300 -> out_A=255 with o_sat=1; other components unaffected (Q=0 -> 0). The following vector with no overflow -> o_sat=0.
- Handshake:
  - i_valid held high continuously with changing inputs -> accepts only at i_ready edges, one result per 5 cycles.
  - A vector presented during CALC is never reflected in outputs.
  - o_valid is never wider than one cycle.
- Reset mid-operation: assert rst at E2 of a CALC -> no o_valid for that vector; outputs 0 the cycle after reset; a new vector accepted immediately afterward produces correct results.
